// File: rtl/vj_stream_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | vj_stream_pkg                                                      |
// | Shared types and default geometry for the streaming integral image.|
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`ifndef LAPTOP_WIDTH
`define LAPTOP_WIDTH 40
`endif
`ifndef LAPTOP_HEIGHT
`define LAPTOP_HEIGHT 30
`endif

package vj_stream_pkg;

   localparam int DEF_WIDTH_LIMIT  = `LAPTOP_WIDTH;
   localparam int DEF_HEIGHT_LIMIT = `LAPTOP_HEIGHT;
   localparam int DEF_SUM_W        = 32;
   localparam int DEF_SQ_W         = 40;

   localparam int COL_W = $clog2(DEF_WIDTH_LIMIT);
   localparam int ROW_W = $clog2(DEF_HEIGHT_LIMIT);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // Row-buffer word layout at the default sum widths
   typedef struct packed {
      logic [DEF_SUM_W-1:0] sum;
      logic [DEF_SQ_W-1:0]  sq;
   } rowbuf_entry_t;

endpackage

`default_nettype wire

// File: rtl/int_img_row_buf.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | int_img_row_buf                                                    |
// | One-row store, combinational read, read-before-write same address. |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module int_img_row_buf #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 72
) (
   input  logic                     clk,
   input  logic                     i_we,
   input  logic [$clog2(DEPTH)-1:0] i_addr,
   input  logic [DATA_W-1:0]        i_wdata,
   output logic [DATA_W-1:0]        o_rdata
);

   logic [DATA_W-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_addr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_addr];

endmodule

`default_nettype wire

// File: rtl/int_img_stream.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | int_img_stream                                                     |
// | Streaming integral / squared-integral image, one pixel per clock.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`ifndef LAPTOP_WIDTH
`define LAPTOP_WIDTH 40
`endif
`ifndef LAPTOP_HEIGHT
`define LAPTOP_HEIGHT 30
`endif

module int_img_stream
   import vj_stream_pkg::*;
#(
   parameter int WIDTH_LIMIT  = `LAPTOP_WIDTH,
   parameter int HEIGHT_LIMIT = `LAPTOP_HEIGHT,
   parameter int PIX_W        = 8,
   parameter int SUM_W        = 32,
   parameter int SQ_W         = 40
) (
   input  logic                            clock,
   input  logic                            reset_n,
   input  logic                            sq_en,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic                            in_sof,
   input  logic [PIX_W-1:0]                in_pix,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [SUM_W-1:0]                out_sum,
   output logic [SQ_W-1:0]                 out_sq,
   output logic [$clog2(HEIGHT_LIMIT)-1:0] out_row,
   output logic [$clog2(WIDTH_LIMIT)-1:0]  out_col,
   output logic                            frame_done,
   output logic                            sof_err
);

   localparam int c_cw = $clog2(WIDTH_LIMIT);
   localparam int c_rw = $clog2(HEIGHT_LIMIT);
   localparam int c_ew = SUM_W + SQ_W;
   localparam logic [c_cw-1:0] c_col_last = c_cw'(WIDTH_LIMIT - 1);
   localparam logic [c_rw-1:0] c_row_last = c_rw'(HEIGHT_LIMIT - 1);

   state_t              r_state;
   state_t              w_state_next;
   logic [c_rw-1:0]     r_row;
   logic [c_cw-1:0]     r_col;
   logic [c_rw-1:0]     w_row;
   logic [c_cw-1:0]     w_col;
   logic [SUM_W-1:0]    r_rs;
   logic [SQ_W-1:0]     r_rsq;
   logic                r_sq_en;
   logic [SUM_W-1:0]    w_rs;
   logic [SQ_W-1:0]     w_rsq;
   logic                w_sq_en;
   logic                w_accept;
   logic                w_start;
   logic                w_proc;
   logic                w_last;
   logic [2*PIX_W-1:0]  w_pix_sq;
   logic [SUM_W-1:0]    w_above_sum;
   logic [SQ_W-1:0]     w_above_sq;
   logic [SUM_W-1:0]    w_sum;
   logic [SQ_W-1:0]     w_sq;
   logic [c_ew-1:0]     w_rd_data;
   logic [c_ew-1:0]     w_wr_data;
   logic                r_out_valid;
   logic [SUM_W-1:0]    r_out_sum;
   logic [SQ_W-1:0]     r_out_sq;
   logic [c_rw-1:0]     r_out_row;
   logic [c_cw-1:0]     r_out_col;
   logic                r_out_last;
   logic                r_sof_err;

   assign in_ready = reset_n && (!r_out_valid || out_ready);
   assign w_accept = in_valid && in_ready;
   assign w_start  = w_accept && in_sof;
   // Non-SOF pixels in IDLE are consumed but produce nothing
   assign w_proc   = w_accept && (in_sof || (r_state == RUN));

   // An SOF pixel always lands at (0,0), even mid-frame
   assign w_row   = w_start ? '0 : r_row;
   assign w_col   = w_start ? '0 : r_col;
   assign w_sq_en = w_start ? sq_en : r_sq_en;
   assign w_last  = (w_row == c_row_last) && (w_col == c_col_last);

   assign w_pix_sq = (2*PIX_W)'(in_pix) * (2*PIX_W)'(in_pix);
   assign w_rs     = ((w_col == '0) ? '0 : r_rs) + SUM_W'(in_pix);
   assign w_rsq    = w_sq_en ? (((w_col == '0) ? '0 : r_rsq) + SQ_W'(w_pix_sq)) : '0;

   assign {w_above_sum, w_above_sq} = (w_row == '0) ? '0 : w_rd_data;
   assign w_sum     = w_rs + w_above_sum;
   assign w_sq      = w_sq_en ? (w_rsq + w_above_sq) : '0;
   assign w_wr_data = {w_sum, w_sq};

   int_img_row_buf #(
      .DEPTH  (WIDTH_LIMIT),
      .DATA_W (c_ew)
   ) u_row_buf (
      .clk     (clock),
      .i_we    (w_proc),
      .i_addr  (w_col),
      .i_wdata (w_wr_data),
      .o_rdata (w_rd_data)
   );

   always_comb begin
      w_state_next = r_state;
      if (w_proc) begin
         w_state_next = w_last ? IDLE : RUN;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_row       <= '0;
         r_col       <= '0;
         r_rs        <= '0;
         r_rsq       <= '0;
         r_sq_en     <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_sum   <= '0;
         r_out_sq    <= '0;
         r_out_row   <= '0;
         r_out_col   <= '0;
         r_out_last  <= 1'b0;
         r_sof_err   <= 1'b0;
      end else begin
         if (w_proc) begin
            r_rs    <= w_rs;
            r_rsq   <= w_rsq;
            r_sq_en <= w_sq_en;
            if (w_col == c_col_last) begin
               r_col <= '0;
               r_row <= (w_row == c_row_last) ? '0 : w_row + 1'b1;
            end else begin
               r_col <= w_col + 1'b1;
               r_row <= w_row;
            end
            r_out_valid <= 1'b1;
            r_out_sum   <= w_sum;
            r_out_sq    <= w_sq;
            r_out_row   <= w_row;
            r_out_col   <= w_col;
            r_out_last  <= w_last;
         end else if (out_ready) begin
            r_out_valid <= 1'b0;
         end
         // (0,0) is never the position while in RUN, so any SOF here is misplaced
         if (w_start && (r_state == RUN)) begin
            r_sof_err <= 1'b1;
         end
      end
   end

   assign out_valid  = r_out_valid;
   assign out_sum    = r_out_sum;
   assign out_sq     = r_out_sq;
   assign out_row    = r_out_row;
   assign out_col    = r_out_col;
   assign frame_done = r_out_valid && out_ready && r_out_last;
   assign sof_err    = r_sof_err;

endmodule

`default_nettype wire

// File: tb/tb_int_img_stream.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_int_img_stream                                                  |
// | Scoreboard bench: rectangle-sum reference model vs. two DUT sizes. |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_int_img_stream;

   localparam int SW = 4;
   localparam int SH = 3;
   localparam int BW = 40;
   localparam int BH = 30;

   typedef struct {
      logic [63:0] sum;
      logic [63:0] sq;
      int          row;
      int          col;
      bit          last;
   } exp_t;

   logic clock = 1'b0;
   always #5 clock = ~clock;
   logic reset_n = 1'b0;

   logic        s_sq_en = 1'b0, s_in_valid = 1'b0, s_in_sof = 1'b0, s_out_ready = 1'b1;
   logic [7:0]  s_in_pix = '0;
   logic        s_in_ready, s_out_valid, s_frame_done, s_sof_err;
   logic [31:0] s_out_sum;
   logic [39:0] s_out_sq;
   logic [1:0]  s_out_row, s_out_col;

   logic        b_sq_en = 1'b0, b_in_valid = 1'b0, b_in_sof = 1'b0, b_out_ready = 1'b1;
   logic [7:0]  b_in_pix = '0;
   logic        b_in_ready, b_out_valid, b_frame_done, b_sof_err;
   logic [15:0] b_out_sum;
   logic [39:0] b_out_sq;
   logic [4:0]  b_out_row;
   logic [5:0]  b_out_col;

   int total = 0;
   int bad   = 0;
   int rmode = 0;
   bit gap_en = 1'b0;

   exp_t        q_s[$];
   exp_t        q_b[$];
   int          m_run[2], m_r[2], m_c[2], m_frames[2];
   bit          m_sqen[2];
   int          img[2][BH][BW];
   bit          stall[2];
   logic [63:0] hold_sum[2], hold_sq[2];
   int          fd_cnt[2], n_out[2];
   logic [63:0] obs_sum[2][BH][BW];
   logic [63:0] obs_sq[2][BH][BW];
   logic [63:0] last_sum[2], last_sq[2];

   int_img_stream #(.WIDTH_LIMIT(SW), .HEIGHT_LIMIT(SH), .PIX_W(8), .SUM_W(32), .SQ_W(40)) dut (
      .clock(clock), .reset_n(reset_n), .sq_en(s_sq_en), .in_valid(s_in_valid),
      .in_ready(s_in_ready), .in_sof(s_in_sof), .in_pix(s_in_pix), .out_valid(s_out_valid),
      .out_ready(s_out_ready), .out_sum(s_out_sum), .out_sq(s_out_sq), .out_row(s_out_row),
      .out_col(s_out_col), .frame_done(s_frame_done), .sof_err(s_sof_err)
   );

   int_img_stream #(.WIDTH_LIMIT(BW), .HEIGHT_LIMIT(BH), .PIX_W(8), .SUM_W(16), .SQ_W(40)) dut_big (
      .clock(clock), .reset_n(reset_n), .sq_en(b_sq_en), .in_valid(b_in_valid),
      .in_ready(b_in_ready), .in_sof(b_in_sof), .in_pix(b_in_pix), .out_valid(b_out_valid),
      .out_ready(b_out_ready), .out_sum(b_out_sum), .out_sq(b_out_sq), .out_row(b_out_row),
      .out_col(b_out_col), .frame_done(b_frame_done), .sof_err(b_sof_err)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: the integral at (r,c) is the plain sum of the rectangle (0,0)..(r,c)
   task automatic model_accept(input int d, input int p, input bit sof, input bit sqe);
      int w, h, sumw;
      logic [63:0] s, q;
      exp_t e;
      w    = (d == 0) ? SW : BW;
      h    = (d == 0) ? SH : BH;
      sumw = (d == 0) ? 32 : 16;
      if (!sof && m_run[d] == 0) return;
      if (sof) begin
         m_run[d] = 1; m_r[d] = 0; m_c[d] = 0; m_sqen[d] = sqe;
      end
      img[d][m_r[d]][m_c[d]] = p;
      s = 0; q = 0;
      for (int i = 0; i <= m_r[d]; i++)
         for (int j = 0; j <= m_c[d]; j++) begin
            s += 64'(img[d][i][j]);
            q += 64'(img[d][i][j] * img[d][i][j]);
         end
      e.sum  = s & ((64'd1 << sumw) - 1);
      e.sq   = m_sqen[d] ? (q & ((64'd1 << 40) - 1)) : 64'd0;
      e.row  = m_r[d];
      e.col  = m_c[d];
      e.last = (m_r[d] == h - 1) && (m_c[d] == w - 1);
      if (d == 0) q_s.push_back(e); else q_b.push_back(e);
      m_c[d]++;
      if (m_c[d] == w) begin
         m_c[d] = 0;
         m_r[d]++;
         if (m_r[d] == h) begin
            m_r[d] = 0; m_run[d] = 0; m_frames[d]++;
         end
      end
   endtask

   task automatic mon(input int d, input logic v, input logic r, input logic [63:0] sum,
                      input logic [63:0] sq, input int row, input int col, input logic fd);
      exp_t e;
      bit empty;
      if (!reset_n) begin
         stall[d] = 1'b0;
         return;
      end
      if (stall[d]) begin
         chk("hold_valid", 64'(v), 64'd1);
         chk("hold_sum", sum, hold_sum[d]);
         chk("hold_sq", sq, hold_sq[d]);
      end
      if (fd === 1'b1) fd_cnt[d]++;
      if (v && r) begin
         n_out[d]++;
         empty = (d == 0) ? (q_s.size() == 0) : (q_b.size() == 0);
         if (empty) begin
            total++; bad++;
            $display("FAIL unexpected_output dut%0d: got sum=%0d at (%0d,%0d) expected none", d, sum, row, col);
         end else begin
            e = (d == 0) ? q_s.pop_front() : q_b.pop_front();
            chk("out_sum", sum, e.sum);
            chk("out_sq", sq, e.sq);
            chk("out_row", 64'(row), 64'(e.row));
            chk("out_col", 64'(col), 64'(e.col));
            chk("frame_done_at_transfer", 64'(fd), 64'(e.last));
            if (row < BH && col < BW) begin
               obs_sum[d][row][col] = sum;
               obs_sq[d][row][col]  = sq;
            end
            last_sum[d] = sum;
            last_sq[d]  = sq;
         end
      end else begin
         chk("frame_done_idle", 64'(fd), 64'd0);
      end
      stall[d]    = v && !r;
      hold_sum[d] = sum;
      hold_sq[d]  = sq;
   endtask

   always @(negedge clock) begin
      mon(0, s_out_valid, s_out_ready, 64'(s_out_sum), 64'(s_out_sq), int'(s_out_row), int'(s_out_col), s_frame_done);
      mon(1, b_out_valid, b_out_ready, 64'(b_out_sum), 64'(b_out_sq), int'(b_out_row), int'(b_out_col), b_frame_done);
   end

   initial begin
      forever begin
         @(posedge clock);
         #1;
         case (rmode)
            0: s_out_ready = 1'b1;
            1: s_out_ready = ~s_out_ready;
            2: s_out_ready = 1'($urandom_range(0, 1));
            default: s_out_ready = 1'b0;
         endcase
      end
   end

   task automatic send(input int d, input int p, input bit sof, input bit sqe);
      int n;
      bit acc;
      if (gap_en) repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
      if (d == 0) begin
         s_in_valid = 1'b1; s_in_pix = 8'(p); s_in_sof = sof; s_sq_en = sqe;
      end else begin
         b_in_valid = 1'b1; b_in_pix = 8'(p); b_in_sof = sof; b_sq_en = sqe;
      end
      n = 0; acc = 1'b0;
      while (!acc && n < 200) begin
         @(negedge clock);
         acc = (d == 0) ? s_in_ready : b_in_ready;
         @(posedge clock);
         #1;
         n++;
      end
      s_in_valid = 1'b0; s_in_sof = 1'b0;
      b_in_valid = 1'b0; b_in_sof = 1'b0;
      if (!acc) begin
         total++; bad++;
         $display("FAIL accept_timeout dut%0d: got no in_ready expected accept", d);
      end else begin
         model_accept(d, p, sof, sqe);
      end
   endtask

   task automatic drain(input int d);
      int n;
      n = 0;
      while (((d == 0) ? q_s.size() : q_b.size()) != 0 && n < 2000) begin
         @(posedge clock); #1; n++;
      end
      if (n >= 2000) begin
         total++; bad++;
         $display("FAIL drain_timeout dut%0d: got %0d pending expected 0", d,
                  (d == 0) ? q_s.size() : q_b.size());
      end
      repeat (2) begin @(posedge clock); #1; end
   endtask

   task automatic send_frame_s(input int kind, input bit sqe);
      for (int k = 0; k < SW * SH; k++) begin
         case (kind)
            0: send(0, 1, k == 0, sqe);
            1: send(0, k, k == 0, sqe);
            default: send(0, int'($urandom_range(0, 255)), k == 0, sqe);
         endcase
      end
   endtask

   initial begin
      int n0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      chk("rst_out_valid", 64'(s_out_valid), 0);
      chk("rst_out_sum", 64'(s_out_sum), 0);
      chk("rst_out_sq", 64'(s_out_sq), 0);
      chk("rst_out_row", 64'(s_out_row), 0);
      chk("rst_out_col", 64'(s_out_col), 0);
      chk("rst_frame_done", 64'(s_frame_done), 0);
      chk("rst_sof_err", 64'(s_sof_err), 0);
      chk("rst_in_ready", 64'(s_in_ready), 0);
      chk("rst_big_valid", 64'(b_out_valid), 0);
      @(posedge clock); #1;
      reset_n = 1'b1;
      @(posedge clock); #1;

      // all-ones frame: integral (r+1)(c+1)
      send_frame_s(0, 1'b1);
      drain(0);
      chk("ones_sum_2_3", obs_sum[0][2][3], 64'd12);
      chk("ones_sq_2_3", obs_sq[0][2][3], 64'd12);
      chk("ones_sum_1_2", obs_sum[0][1][2], 64'd6);
      chk("ones_frame_done_cnt", 64'(fd_cnt[0]), 64'd1);

      // ramp 0..11
      send_frame_s(1, 1'b1);
      drain(0);
      chk("ramp_sum_2_3", obs_sum[0][2][3], 64'd66);
      chk("ramp_sq_2_3", obs_sq[0][2][3], 64'd506);
      chk("ramp_sum_1_1", obs_sum[0][1][1], 64'd10);
      chk("ramp_sq_1_1", obs_sq[0][1][1], 64'd42);

      // ramp again under toggled out_ready and input gaps
      rmode = 1; gap_en = 1'b1;
      n0 = n_out[0];
      send_frame_s(1, 1'b1);
      drain(0);
      chk("stalled_out_count", 64'(n_out[0] - n0), 64'd12);
      chk("stalled_sum_2_3", obs_sum[0][2][3], 64'd66);

      // random pixels, random backpressure, random sq_en
      rmode = 2;
      repeat (3) send_frame_s(2, 1'($urandom_range(0, 1)));
      drain(0);
      rmode = 0; gap_en = 1'b0;
      chk("frames_done_cnt", 64'(fd_cnt[0]), 64'(m_frames[0]));
      chk("sof_err_clean", 64'(s_sof_err), 64'd0);

      // misplaced SOF at (1,2) restarts the frame
      for (int k = 0; k < 6; k++) send(0, k + 3, k == 0, 1'b1);
      n0 = fd_cnt[0];
      send(0, 77, 1'b1, 1'b1);
      drain(0);
      chk("sof_err_set", 64'(s_sof_err), 64'd1);
      chk("restart_sum_0_0", obs_sum[0][0][0], 64'd77);
      chk("aborted_no_frame_done", 64'(fd_cnt[0] - n0), 64'd0);
      for (int k = 1; k < SW * SH; k++) send(0, int'($urandom_range(0, 255)), 1'b0, 1'b1);
      drain(0);
      chk("restarted_frame_done", 64'(fd_cnt[0] - n0), 64'd1);
      chk("sof_err_sticky", 64'(s_sof_err), 64'd1);

      // non-SOF pixels while idle are dropped
      n0 = n_out[0];
      repeat (3) send(0, 9, 1'b0, 1'b1);
      drain(0);
      chk("idle_drop_count", 64'(n_out[0] - n0), 64'd0);

      // reset mid-frame with an output stalled
      for (int k = 0; k < 4; k++) send(0, k + 1, k == 0, 1'b1);
      drain(0);
      rmode = 3;
      @(posedge clock); #1;
      send(0, 5, 1'b0, 1'b1);
      repeat (2) begin @(posedge clock); #1; end
      reset_n = 1'b0;
      @(posedge clock); #1;
      reset_n = 1'b1;
      q_s.delete(); q_b.delete();
      m_run[0] = 0; m_run[1] = 0;
      @(negedge clock);
      chk("mid_rst_valid", 64'(s_out_valid), 0);
      chk("mid_rst_sum", 64'(s_out_sum), 0);
      chk("mid_rst_row", 64'(s_out_row), 0);
      chk("mid_rst_col", 64'(s_out_col), 0);
      chk("mid_rst_sof_err", 64'(s_sof_err), 0);
      @(posedge clock); #1;
      rmode = 0;
      n0 = n_out[0];
      repeat (3) send(0, 200, 1'b0, 1'b1);
      drain(0);
      chk("post_rst_drop", 64'(n_out[0] - n0), 64'd0);
      send_frame_s(2, 1'b0);
      drain(0);
      chk("sq_off_2_3", obs_sq[0][2][3], 64'd0);
      chk("post_rst_frame_cnt", 64'(n_out[0] - n0), 64'd12);

      // large frame of 255s with a 16-bit integral
      for (int k = 0; k < BW * BH; k++) send(1, 255, k == 0, 1'b1);
      drain(1);
      chk("big_last_sum", last_sum[1], 64'd43856);
      chk("big_last_sq", last_sq[1], 64'd78030000);
      chk("big_frame_done_cnt", 64'(fd_cnt[1]), 64'd1);
      chk("big_sof_err", 64'(b_sof_err), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
